// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared types, widths and the twiddle ROM generator for FFT stages.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int INTEGER_SIZE = 8;
    localparam int FRACT_SIZE   = 8;
    localparam int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // pi in Q30 fixed point
    localparam longint PI_Q30 = 64'sd3373259426;

    // round(2^fract * cos(2*pi*m/n)), half away from zero, via a Q30 Taylor
    // series so the table can be built at elaboration without real math.
    function automatic int quarter_cos(input int m, input int n, input int fract);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        longint half;
        x    = (longint'(2) * PI_Q30 * longint'(m)) / longint'(n);
        x2   = (x * x) >>> 30;
        term = longint'(1) << 30;
        sum  = 64'sd0;
        half = longint'(1) << 29;
        for (int i = 0; i < 12; i++) begin
            sum  = sum + term;
            term = -(((term * x2) >>> 30) / longint'((2 * i + 1) * (2 * i + 2)));
        end
        scaled = sum * (longint'(1) << fract);
        if (scaled >= 0) begin
            return int'((scaled + half) >>> 30);
        end
        return -int'(((-scaled) + half) >>> 30);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_sequencer_if
// Brief    : Sample-in / twiddle-out bundle between the stage and its sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface twiddle_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 7
);
    logic                         in_valid;
    logic                         start;
    logic                         inverse;
    logic signed [DATA_WIDTH-1:0] tw_r;
    logic signed [DATA_WIDTH-1:0] tw_i;
    logic                         tw_valid;
    logic                         tw_bypass;
    logic [IDX_W-1:0]             tw_index;
    logic                         frame_done;
    logic                         busy;

    modport master (
        output in_valid, start, inverse,
        input  tw_r, tw_i, tw_valid, tw_bypass, tw_index, frame_done, busy
    );

    modport slave (
        input  in_valid, start, inverse,
        output tw_r, tw_i, tw_valid, tw_bypass, tw_index, frame_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/twiddle_sequencer_rom.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_rom
// Brief    : Quarter-wave cosine lookup with symmetry fold and conjugate select.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int FFT_SIZE   = 128,
    parameter int FRACT_SIZE = 8,
    parameter int DATA_WIDTH = 16,
    parameter int K_W        = $clog2(FFT_SIZE) - 1
) (
    input  logic [K_W-1:0]               i_k,
    input  logic                         i_inverse,
    output logic signed [DATA_WIDTH-1:0] o_cos,
    output logic signed [DATA_WIDTH-1:0] o_imag
);

    localparam int QUARTER = FFT_SIZE / 4;

    logic signed [DATA_WIDTH-1:0] w_rom [0:QUARTER];
    logic [K_W-1:0]               w_cidx;
    logic [K_W-1:0]               w_sidx;
    logic                         w_neg_cos;
    logic signed [DATA_WIDTH-1:0] w_sin;

    generate
        for (genvar m = 0; m <= QUARTER; m++) begin : g_rom
            assign w_rom[m] = DATA_WIDTH'(quarter_cos(m, FFT_SIZE, FRACT_SIZE));
        end
    endgenerate

    // Second quadrant folds onto the first: cos = -C[N/2-k], sin = C[k-N/4].
    always_comb begin
        w_cidx    = i_k;
        w_sidx    = K_W'(QUARTER) - i_k;
        w_neg_cos = 1'b0;
        if (i_k > K_W'(QUARTER)) begin
            w_cidx    = K_W'(QUARTER) - (i_k - K_W'(QUARTER));
            w_sidx    = i_k - K_W'(QUARTER);
            w_neg_cos = 1'b1;
        end
    end

    assign o_cos  = w_neg_cos ? -w_rom[w_cidx] : w_rom[w_cidx];
    assign w_sin  = w_rom[w_sidx];
    assign o_imag = i_inverse ? w_sin : -w_sin;

endmodule
`default_nettype wire

// File: rtl/twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_sequencer
// Brief    : Per-sample twiddle generator for one radix-2 DIF SDF stage.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int INTEGER_SIZE = 8,
    parameter int FRACT_SIZE   = 8,
    parameter int FFT_SIZE     = 128,
    parameter int STAGE        = 0
) (
    input  logic               clk,
    input  logic               rst,
    twiddle_sequencer_if.slave bus
);

    localparam int DW     = INTEGER_SIZE + FRACT_SIZE;
    localparam int IDX_W  = $clog2(FFT_SIZE);
    localparam int K_W    = IDX_W - 1;
    localparam int SPAN   = FFT_SIZE >> STAGE;
    localparam int HALF   = SPAN / 2;
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(FFT_SIZE - 1);
    localparam logic signed [DW-1:0] ONE = DW'(1) << FRACT_SIZE;

    seq_state_t              state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    inv_q, inv_d;
    logic signed [DW-1:0]    tw_r_q, tw_r_d;
    logic signed [DW-1:0]    tw_i_q, tw_i_d;
    logic                    tw_valid_q, tw_valid_d;
    logic                    tw_bypass_q, tw_bypass_d;
    logic [IDX_W-1:0]        tw_index_q, tw_index_d;
    logic                    frame_done_q, frame_done_d;

    logic                    w_start;
    logic                    w_accept;
    logic [IDX_W-1:0]        w_n;
    logic                    w_inv;
    logic [IDX_W-1:0]        w_pos;
    logic                    w_bypass;
    logic [K_W-1:0]          w_k;
    logic signed [DW-1:0]    w_cos;
    logic signed [DW-1:0]    w_imag;

    // A start always wins, even mid-frame: it restarts at n=0 and relatches inverse.
    assign w_start  = bus.in_valid && bus.start;
    assign w_accept = w_start || (bus.in_valid && (state_q == RUN));
    assign w_n      = w_start ? '0 : cnt_q;
    assign w_inv    = w_start ? bus.inverse : inv_q;
    assign w_pos    = w_n & IDX_W'(SPAN - 1);
    assign w_bypass = (w_pos < IDX_W'(HALF));
    assign w_k      = K_W'((w_pos - IDX_W'(HALF)) << STAGE);

    twiddle_rom #(
        .FFT_SIZE   (FFT_SIZE),
        .FRACT_SIZE (FRACT_SIZE),
        .DATA_WIDTH (DW),
        .K_W        (K_W)
    ) u_rom (
        .i_k       (w_k),
        .i_inverse (w_inv),
        .o_cos     (w_cos),
        .o_imag    (w_imag)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inv_d        = inv_q;
        tw_r_d       = tw_r_q;
        tw_i_d       = tw_i_q;
        tw_bypass_d  = tw_bypass_q;
        tw_index_d   = tw_index_q;
        tw_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        if (w_accept) begin
            tw_valid_d  = 1'b1;
            tw_index_d  = w_n;
            tw_bypass_d = w_bypass;
            tw_r_d      = w_bypass ? ONE : w_cos;
            tw_i_d      = w_bypass ? '0  : w_imag;
            inv_d       = w_inv;
            cnt_d       = w_n + 1'b1;
            if (w_n == LAST) begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
            end else begin
                state_d      = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            inv_q        <= 1'b0;
            tw_r_q       <= '0;
            tw_i_q       <= '0;
            tw_valid_q   <= 1'b0;
            tw_bypass_q  <= 1'b0;
            tw_index_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inv_q        <= inv_d;
            tw_r_q       <= tw_r_d;
            tw_i_q       <= tw_i_d;
            tw_valid_q   <= tw_valid_d;
            tw_bypass_q  <= tw_bypass_d;
            tw_index_q   <= tw_index_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tw_r       = tw_r_q;
    assign bus.tw_i       = tw_i_q;
    assign bus.tw_valid   = tw_valid_q;
    assign bus.tw_bypass  = tw_bypass_q;
    assign bus.tw_index   = tw_index_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_sequencer
// Brief    : Self-checking bench driving a STAGE=0 and a STAGE=2 sequencer in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, start, inverse;
    int   phase;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    twiddle_sequencer_if #(.DATA_WIDTH(16), .IDX_W(7)) if0 ();
    twiddle_sequencer_if #(.DATA_WIDTH(16), .IDX_W(7)) if2 ();

    assign if0.in_valid = in_valid;
    assign if0.start    = start;
    assign if0.inverse  = inverse;
    assign if2.in_valid = in_valid;
    assign if2.start    = start;
    assign if2.inverse  = inverse;

    twiddle_sequencer #(.INTEGER_SIZE(8), .FRACT_SIZE(8), .FFT_SIZE(128), .STAGE(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    twiddle_sequencer #(.INTEGER_SIZE(8), .FRACT_SIZE(8), .FFT_SIZE(128), .STAGE(2))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // Twiddle straight from the math: W_N^k with k from the stage's butterfly position.
    task automatic twm(input int n, input int s, input bit inv,
                       output int r, output int i, output bit byp);
        int  span, pos, k;
        real th;
        int  sn;
        span = 128 >> s;
        pos  = n % span;
        if (pos < span / 2) begin
            byp = 1'b1; r = 256; i = 0;
        end else begin
            k   = (pos - span / 2) << s;
            th  = 2.0 * 3.14159265358979 * real'(k) / 128.0;
            r   = rnd(256.0 * $cos(th));
            sn  = rnd(256.0 * $sin(th));
            i   = inv ? sn : -sn;
            byp = 1'b0;
        end
    endtask

    bit m_run;
    int m_cnt;
    bit m_inv;
    bit e_valid, e_fd, e_busy, e_byp0, e_byp2;
    int e_r0, e_i0, e_r2, e_i2, e_idx, e_phase;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 0; m_cnt = 0; m_inv = 0;
            e_valid = 0; e_fd = 0; e_busy = 0; e_byp0 = 0; e_byp2 = 0;
            e_r0 = 0; e_i0 = 0; e_r2 = 0; e_i2 = 0; e_idx = 0; e_phase = 0;
        end else begin
            e_valid = 0;
            e_fd    = 0;
            if (in_valid && (start || m_run)) begin
                int n;
                n = start ? 0 : m_cnt;
                if (start) m_inv = inverse;
                twm(n, 0, m_inv, e_r0, e_i0, e_byp0);
                twm(n, 2, m_inv, e_r2, e_i2, e_byp2);
                e_valid = 1;
                e_idx   = n;
                e_phase = phase;
                e_fd    = (n == 127);
                m_cnt   = n + 1;
                m_run   = (n != 127);
            end
            e_busy = m_run;
        end
    end

    always @(negedge clk) begin
        chk("valid0", int'(if0.tw_valid), int'(e_valid));
        chk("valid2", int'(if2.tw_valid), int'(e_valid));
        chk("fdone0", int'(if0.frame_done), int'(e_fd));
        chk("busy0", int'(if0.busy), int'(e_busy));
        chk("busy2", int'(if2.busy), int'(e_busy));
        chk("r0", int'(if0.tw_r), e_r0);
        chk("i0", int'(if0.tw_i), e_i0);
        chk("idx0", int'(if0.tw_index), e_idx);
        chk("byp0", int'(if0.tw_bypass), int'(e_byp0));
        chk("r2", int'(if2.tw_r), e_r2);
        chk("i2", int'(if2.tw_i), e_i2);
        chk("idx2", int'(if2.tw_index), e_idx);
        chk("byp2", int'(if2.tw_bypass), int'(e_byp2));
        if (e_valid && e_phase == 1) begin
            case (e_idx)
                0, 63: begin chk("lit_byp_lo", int'(if0.tw_bypass), 1);
                             chk("lit_r_lo", int'(if0.tw_r), 256); chk("lit_i_lo", int'(if0.tw_i), 0); end
                64:  begin chk("lit64_byp", int'(if0.tw_bypass), 0);
                           chk("lit64_r", int'(if0.tw_r), 256); chk("lit64_i", int'(if0.tw_i), 0); end
                80:  begin chk("lit80_r", int'(if0.tw_r), 181); chk("lit80_i", int'(if0.tw_i), -181); end
                96:  begin chk("lit96_r", int'(if0.tw_r), 0); chk("lit96_i", int'(if0.tw_i), -256); end
                112: begin chk("lit112_r", int'(if0.tw_r), -181); chk("lit112_i", int'(if0.tw_i), -181); end
                127: chk("lit127_fdone", int'(if0.frame_done), 1);
                default: ;
            endcase
            case (e_idx)
                8, 40: chk("s2_lit_byp", int'(if2.tw_bypass), 1);
                24, 56: begin chk("s2_lit_r_q", int'(if2.tw_r), 0); chk("s2_lit_i_q", int'(if2.tw_i), -256); end
                28:  begin chk("s2_lit28_r", int'(if2.tw_r), -181); chk("s2_lit28_i", int'(if2.tw_i), -181); end
                default: ;
            endcase
        end
        if (e_valid && e_phase == 2) begin
            case (e_idx)
                80:  begin chk("inv80_r", int'(if0.tw_r), 181); chk("inv80_i", int'(if0.tw_i), 181); end
                112: begin chk("inv112_r", int'(if0.tw_r), -181); chk("inv112_i", int'(if0.tw_i), 181); end
                default: ;
            endcase
        end
    end

    task automatic step(input bit v, input bit s, input bit inv);
        in_valid = v; start = s; inverse = inv;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit v;
        rst = 1'b0; in_valid = 0; start = 0; inverse = 0; phase = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(if0.tw_valid), 0);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_r", int'(if0.tw_r), 0);
        rst = 1'b1;

        repeat (3) step(1, 0, 1);
        step(0, 0, 0);

        phase = 1;
        step(1, 1, 0);
        for (int n = 1; n < 128; n++) step(1, 0, 0);
        repeat (2) step(0, 0, 0);

        phase = 2;
        step(1, 1, 1);
        for (int n = 1; n < 128; n++) step(1, 0, n[0]);
        repeat (2) step(0, 0, 0);

        phase = 3;
        step(1, 1, 0);
        cnt = 1;
        while (cnt < 128) begin
            v = 1'($urandom_range(0, 1));
            step(v, 0, 1'($urandom_range(0, 1)));
            if (v) cnt++;
        end
        repeat (3) step(0, 0, 0);

        phase = 4;
        step(1, 1, 0);
        for (int n = 1; n < 50; n++) step(1, 0, 0);
        step(1, 1, 1);
        for (int n = 1; n < 128; n++) step(1, 0, 0);
        repeat (2) step(0, 0, 0);

        phase = 5;
        step(1, 1, 0);
        for (int n = 1; n < 70; n++) step(1, 0, 0);
        in_valid = 1; start = 0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", int'(if0.tw_valid), 0);
        chk("arst_busy", int'(if0.busy), 0);
        chk("arst_idx", int'(if0.tw_index), 0);
        chk("arst_r", int'(if0.tw_r), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        for (int n = 1; n < 128; n++) step(1, 0, 0);
        repeat (2) step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
